// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard scoreboard.
// Latency: none (types and constants only).
// Backpressure: none; HAZARD_SCOREBOARD_FWD_EN is consumed by hazard_scoreboard.
package hazard_pkg;

  // Default register index width (32 architectural registers).
  localparam int IDX_W_DEF = 5;

  // One tracked in-flight instruction: valid, destination, is-load.
  typedef struct packed {
    logic                 v;
    logic [IDX_W_DEF-1:0] rd;
    logic                 ld;
  } sb_entry_t;

  // EX operand bypass select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/sb_match.sv
// Youngest-producer priority encoder for one source operand against the scoreboard.
// Latency: purely combinational.
// Backpressure: none; result feeds the stall and bypass logic directly.
module sb_match
  import hazard_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = 3,
  parameter int POS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_used,
  input  logic [IDX_W-1:0]      i_src,
  input  sb_entry_t [DEPTH-1:0] i_entries,
  output logic                  o_hit,
  output logic [POS_W-1:0]      o_idx,
  output logic                  o_ld
);

  // x0 reads never depend on anything, and unused operands cannot hazard.
  logic w_src_ok;
  assign w_src_ok = i_used && (i_src != '0);

  // Scan oldest to youngest so the lowest matching index (youngest producer) wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    o_ld  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_src_ok && i_entries[k].v && (i_entries[k].rd == IDX_W_DEF'(i_src))) begin
        o_hit = 1'b1;
        o_idx = POS_W'(k);
        o_ld  = i_entries[k].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight rd past ID, drives the ID stall, counts stall cycles.
// Latency: stall is same-cycle; bypass selects register with issue and are valid in EX.
// Backpressure: stall holds PC and IF/ID; flush overrides stall. HAZARD_SCOREBOARD_FWD_EN enables bypass.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int IDX_W       = $clog2(NUM_REGS),
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 0,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [IDX_W-1:0]           id_rs1,
  input  logic [IDX_W-1:0]           id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [IDX_W-1:0]           id_rd,
  input  logic                       id_reg_wr,
  input  logic                       id_is_load,
  input  logic                       flush,
  output logic                       stall,
  output logic [1:0]                 ex_fwd_a,
  output logic [1:0]                 ex_fwd_b,
  output logic [$clog2(DEPTH+1)-1:0] inflight_cnt,
  output logic [CNT_W-1:0]           stall_count
);

  localparam int POS_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_IF_W = $clog2(DEPTH + 1);

  // Entry 0 is the instruction in EX, entry DEPTH-1 the one in WB.
  sb_entry_t [DEPTH-1:0] r_sb;
  sb_entry_t             w_new;
  logic                  w_issue;
  logic                  w_hazard;
  logic                  w_hit_a, w_hit_b, w_ld_a, w_ld_b;
  logic [POS_W-1:0]      w_idx_a, w_idx_b;
  logic [CNT_IF_W-1:0]   w_inflight;
  logic [CNT_W-1:0]      r_stall_cnt;

  sb_match #(.IDX_W(IDX_W), .DEPTH(DEPTH), .POS_W(POS_W)) u_match_rs1 (
    .i_used(id_rs1_used), .i_src(id_rs1), .i_entries(r_sb),
    .o_hit(w_hit_a), .o_idx(w_idx_a), .o_ld(w_ld_a)
  );

  sb_match #(.IDX_W(IDX_W), .DEPTH(DEPTH), .POS_W(POS_W)) u_match_rs2 (
    .i_used(id_rs2_used), .i_src(id_rs2), .i_entries(r_sb),
    .o_hit(w_hit_b), .o_idx(w_idx_b), .o_ld(w_ld_b)
  );

`ifdef HAZARD_SCOREBOARD_FWD_EN
  // Only a load still in EX cannot be bypassed; everything else is forwarded.
  assign w_hazard = (w_hit_a && (w_idx_a == '0) && w_ld_a) ||
                    (w_hit_b && (w_idx_b == '0) && w_ld_b);

  // Producer at entry k is one stage further along when the consumer reaches EX.
  // The WB-stage producer writes this cycle and relies on regfile write-through.
  function automatic fwd_sel_e fwd_sel(input logic hit, input logic [POS_W-1:0] idx);
    fwd_sel_e sel;
    logic     not_last;
    not_last = (int'(idx) < DEPTH - 1);
    sel      = FWD_RF;
    if (hit && not_last && (idx == POS_W'(0)))      sel = FWD_MEM;
    else if (hit && not_last && (idx == POS_W'(1))) sel = FWD_WB;
    return sel;
  endfunction

  fwd_sel_e r_fwd_a, r_fwd_b;

  // Bypass selects travel with the issuing instruction; bubbles read the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (w_issue) begin
      r_fwd_a <= fwd_sel(w_hit_a, w_idx_a);
      r_fwd_b <= fwd_sel(w_hit_b, w_idx_b);
    end else begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end
  end

  assign ex_fwd_a = r_fwd_a;
  assign ex_fwd_b = r_fwd_b;
`else
  // Without bypass any in-flight producer of a source blocks issue.
  assign w_hazard = w_hit_a || w_hit_b;
  assign ex_fwd_a = FWD_RF;
  assign ex_fwd_b = FWD_RF;

  logic w_unused;
  assign w_unused = ^{w_idx_a, w_idx_b, w_ld_a, w_ld_b};
`endif

  // A redirect discards the ID instruction, so it never counts as a stall.
  assign stall   = id_valid && !flush && w_hazard;
  assign w_issue = id_valid && !stall && !flush;

  // x0 writes are not tracked; a non-issuing cycle injects a clean bubble.
  always_comb begin
    w_new = '0;
    if (w_issue) begin
      w_new.v  = id_reg_wr && (id_rd != '0);
      w_new.rd = IDX_W_DEF'(id_rd);
      w_new.ld = id_is_load;
    end
  end

  // Advance the scoreboard every cycle; flush squashes the youngest FLUSH_DEPTH entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb <= '0;
    end else begin
      r_sb[0] <= w_new;
      for (int i = 1; i < DEPTH; i++) begin
        r_sb[i] <= (flush && ((i - 1) < FLUSH_DEPTH)) ? '0 : r_sb[i-1];
      end
    end
  end

  // Count live entries.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_inflight = w_inflight + CNT_IF_W'(r_sb[k].v);
    end
  end

  assign inflight_cnt = w_inflight;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule
